// File: rtl/instfetch.sv
// instfetch: instruction fetch unit in front of the instruction queue.
// Holds the PC and looks it up in a direct-mapped icache with one word per line.
// On a miss it issues a single read to the memory controller and waits for the reply.
// Each fetched (inst, pc) pair is pushed to the queue and the PC advances by 4.
// Redirects come from the ROB, the branch predictor and the decoder.
// At most one memory request is outstanding at any time.
//
// Ports:
//   clk_in, rst_in            clock (posedge); synchronous active-high reset
//   rdy_in                    global ready; when low, every register holds its value
//   instqueue_if_rdy_in       the queue can accept a new fetch
//   if_instqueue_*_out        push strobe (one cycle), instruction and pc
//   if_memctrl_*_out          read request (level) and word-aligned address
//   memctrl_if_*_in           reply strobe (one cycle) and data
//   rob/bp/decoder_if_*_in    redirect strobes and targets (rob > bp > decoder)
module instfetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  instqueue_if_rdy_in,
    output logic                  if_instqueue_en_out,
    output logic [INST_WIDTH-1:0] if_instqueue_inst_out,
    output logic [ADDR_WIDTH-1:0] if_instqueue_pc_out,
    output logic                  if_memctrl_en_out,
    output logic [ADDR_WIDTH-1:0] if_memctrl_pc_out,
    input  logic                  memctrl_if_en_in,
    input  logic [INST_WIDTH-1:0] memctrl_if_inst_in,
    input  logic                  rob_if_rst_in,
    input  logic [ADDR_WIDTH-1:0] rob_if_pc_in,
    input  logic                  bp_if_rst_in,
    input  logic [ADDR_WIDTH-1:0] bp_if_pc_in,
    input  logic                  decoder_if_rst_in,
    input  logic [ADDR_WIDTH-1:0] decoder_if_pc_in
);

    localparam int unsigned LINES     = 1 << INDEX_BITS;
    localparam int unsigned LINE_BITS = ADDR_WIDTH - 2;
    localparam int unsigned TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    // Word address of the outstanding request; it also selects the line to fill.
    logic [LINE_BITS-1:0]    req_line;

    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [INST_WIDTH-1:0]   data_q [LINES];

    logic [INDEX_BITS-1:0]   pc_idx_c;
    logic [TAG_BITS-1:0]     pc_tag_c;
    logic [INDEX_BITS-1:0]   req_idx_c;
    logic [TAG_BITS-1:0]     req_tag_c;
    logic                    hit_c;
    logic                    redirect_c;
    logic [ADDR_WIDTH-1:0]   target_c;
    logic                    fill_c;
    logic [ADDR_WIDTH-1:0]   pc_inc_c;

    // Cache lookup, redirect arbitration and fill detection.
    always_comb begin
        pc_idx_c  = pc[INDEX_BITS+1:2];
        pc_tag_c  = pc[ADDR_WIDTH-1:INDEX_BITS+2];
        req_idx_c = req_line[INDEX_BITS-1:0];
        req_tag_c = req_line[LINE_BITS-1:INDEX_BITS];
        hit_c     = valid_q[pc_idx_c] && (tag_q[pc_idx_c] == pc_tag_c);
        pc_inc_c  = pc + ADDR_WIDTH'(4);

        redirect_c = rob_if_rst_in || bp_if_rst_in || decoder_if_rst_in;
        target_c   = decoder_if_pc_in;
        if (bp_if_rst_in) begin
            target_c = bp_if_pc_in;
        end
        if (rob_if_rst_in) begin
            target_c = rob_if_pc_in;
        end

        // Every reply fills the cache, including replies that get discarded.
        fill_c = (state != ST_IDLE) && memctrl_if_en_in;
    end

    // Cache tag/data storage; only the valid bits need a reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill_c) begin
            tag_q[req_idx_c]  <= req_tag_c;
            data_q[req_idx_c] <= memctrl_if_inst_in;
        end
    end

    // Fetch FSM, pc, valid bits and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                 <= ST_IDLE;
            pc                    <= '0;
            req_line              <= '0;
            valid_q               <= '0;
            if_instqueue_en_out   <= 1'b0;
            if_instqueue_inst_out <= '0;
            if_instqueue_pc_out   <= '0;
            if_memctrl_en_out     <= 1'b0;
        end else if (rdy_in) begin
            if_instqueue_en_out <= 1'b0;
            if (fill_c) begin
                valid_q[req_idx_c] <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (redirect_c) begin
                        pc <= target_c;
                    end else if (instqueue_if_rdy_in) begin
                        if (hit_c) begin
                            if_instqueue_en_out   <= 1'b1;
                            if_instqueue_inst_out <= data_q[pc_idx_c];
                            if_instqueue_pc_out   <= pc;
                            pc                    <= pc_inc_c;
                        end else begin
                            if_memctrl_en_out <= 1'b1;
                            req_line          <= pc[ADDR_WIDTH-1:2];
                            state             <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (memctrl_if_en_in) begin
                        if_memctrl_en_out <= 1'b0;
                        state             <= ST_IDLE;
                        if (redirect_c) begin
                            pc <= target_c;
                        end else begin
                            // The queue keeps room for the one in-flight fetch.
                            if_instqueue_en_out   <= 1'b1;
                            if_instqueue_inst_out <= memctrl_if_inst_in;
                            if_instqueue_pc_out   <= pc;
                            pc                    <= pc_inc_c;
                        end
                    end else if (redirect_c) begin
                        pc    <= target_c;
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (redirect_c) begin
                        pc <= target_c;
                    end
                    if (memctrl_if_en_in) begin
                        if_memctrl_en_out <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request address is the held word address; the low two bits are always zero.
    assign if_memctrl_pc_out = {req_line, 2'b00};

endmodule

// File: tb/tb_instfetch.sv
// Scoreboard bench for instfetch: stimulus queues expected pushes and memory requests;
// a push monitor and a memory model pop and compare independently.
module tb_instfetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } push_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        instqueue_if_rdy_in;
    logic        if_instqueue_en_out;
    logic [31:0] if_instqueue_inst_out;
    logic [31:0] if_instqueue_pc_out;
    logic        if_memctrl_en_out;
    logic [31:0] if_memctrl_pc_out;
    logic        memctrl_if_en_in;
    logic [31:0] memctrl_if_inst_in;
    logic        rob_if_rst_in;
    logic [31:0] rob_if_pc_in;
    logic        bp_if_rst_in;
    logic [31:0] bp_if_pc_in;
    logic        decoder_if_rst_in;
    logic [31:0] decoder_if_pc_in;

    int    total = 0;
    int    bad   = 0;
    push_t exp_push [$];
    logic [31:0] exp_req [$];
    bit    mem_busy = 1'b0;

    always #5 clk_in = ~clk_in;

    instfetch dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .instqueue_if_rdy_in   (instqueue_if_rdy_in),
        .if_instqueue_en_out   (if_instqueue_en_out),
        .if_instqueue_inst_out (if_instqueue_inst_out),
        .if_instqueue_pc_out   (if_instqueue_pc_out),
        .if_memctrl_en_out     (if_memctrl_en_out),
        .if_memctrl_pc_out     (if_memctrl_pc_out),
        .memctrl_if_en_in      (memctrl_if_en_in),
        .memctrl_if_inst_in    (memctrl_if_inst_in),
        .rob_if_rst_in         (rob_if_rst_in),
        .rob_if_pc_in          (rob_if_pc_in),
        .bp_if_rst_in          (bp_if_rst_in),
        .bp_if_pc_in           (bp_if_pc_in),
        .decoder_if_rst_in     (decoder_if_rst_in),
        .decoder_if_pc_in      (decoder_if_pc_in)
    );

    // Memory image: word at address a is 0x13 + (a << 8).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h13 + (a << 8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push monitor.
    initial begin
        push_t e;
        forever begin
            @(negedge clk_in);
            if (if_instqueue_en_out === 1'b1) begin
                if (exp_push.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_push: got pc=%0h inst=%0h expected no push",
                             if_instqueue_pc_out, if_instqueue_inst_out);
                end else begin
                    e = exp_push.pop_front();
                    chk("push_pc", 64'(if_instqueue_pc_out), 64'(e.pc));
                    chk("push_inst", 64'(if_instqueue_inst_out), 64'(e.inst));
                end
            end
        end
    end

    // Memory controller model: replies three cycles after a request is raised.
    initial begin
        logic [31:0] addr;
        logic [31:0] ea;
        memctrl_if_en_in   = 1'b0;
        memctrl_if_inst_in = '0;
        forever begin
            @(negedge clk_in);
            if (if_memctrl_en_out === 1'b1 && !rst_in) begin
                mem_busy = 1'b1;
                addr = if_memctrl_pc_out;
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got %0h expected no request", addr);
                end else begin
                    ea = exp_req.pop_front();
                    chk("req_addr", 64'(addr), 64'(ea));
                end
                repeat (2) @(negedge clk_in);
                chk("req_held", {31'd0, if_memctrl_en_out, if_memctrl_pc_out}, {31'd0, 1'b1, addr});
                memctrl_if_en_in   = 1'b1;
                memctrl_if_inst_in = mem_word(addr);
                @(negedge clk_in);
                memctrl_if_en_in = 1'b0;
                mem_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic fetch_one();
        instqueue_if_rdy_in = 1'b1;
        @(negedge clk_in);
        instqueue_if_rdy_in = 1'b0;
    endtask

    task automatic redirect(input logic r, input logic b, input logic d,
                            input logic [31:0] rp, input logic [31:0] bpc, input logic [31:0] dp);
        rob_if_rst_in = r;     rob_if_pc_in = rp;
        bp_if_rst_in = b;      bp_if_pc_in = bpc;
        decoder_if_rst_in = d; decoder_if_pc_in = dp;
        @(negedge clk_in);
        rob_if_rst_in = 1'b0;
        bp_if_rst_in = 1'b0;
        decoder_if_rst_in = 1'b0;
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst, input bit miss);
        if (miss) exp_req.push_back({pc[31:2], 2'b00});
        exp_push.push_back('{inst: inst, pc: pc});
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (exp_req.size() == 0 && exp_push.size() == 0 &&
                !if_memctrl_en_out && !mem_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        bit seen;
        logic [31:0] t6 [3];
        t6[0] = 32'h0; t6[1] = 32'h100; t6[2] = 32'h0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        instqueue_if_rdy_in = 1'b0;
        rob_if_rst_in = 1'b0;     rob_if_pc_in = '0;
        bp_if_rst_in = 1'b0;      bp_if_pc_in = '0;
        decoder_if_rst_in = 1'b0; decoder_if_pc_in = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_push_en", 64'(if_instqueue_en_out), 64'd0);
        chk("rst_mem_en", 64'(if_memctrl_en_out), 64'd0);
        chk("rst_push_data", {if_instqueue_inst_out, if_instqueue_pc_out}, 64'd0);
        chk("rst_mem_pc", 64'(if_memctrl_pc_out), 64'd0);
        rst_in = 1'b0;

        // Cold miss at 0x0, then the next sequential miss is issued right away.
        expect_fetch(32'h0, 32'h13, 1'b1);
        expect_fetch(32'h4, 32'h413, 1'b1);
        instqueue_if_rdy_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (if_instqueue_en_out) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t1_first_push_seen", 64'(seen), 64'd1);
        @(negedge clk_in);
        chk("t1_req4_next_cycle", {31'd0, if_memctrl_en_out, if_memctrl_pc_out}, {31'd0, 1'b1, 32'h4});
        // Queue not ready during WAIT: the reply is still pushed once.
        instqueue_if_rdy_in = 1'b0;
        wait_drain("t1_drain");

        // Queue not ready in IDLE: nothing happens.
        repeat (5) @(negedge clk_in);
        chk("t4_idle_hold", {62'd0, if_instqueue_en_out, if_memctrl_en_out}, 64'd0);

        // Redirect back to 0x0: cache hit, one-cycle latency, no memory traffic.
        redirect(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        expect_fetch(32'h0, 32'h13, 1'b0);
        fetch_one();
        chk("t2_hit_latency", 64'(if_instqueue_en_out), 64'd1);
        chk("t2_hit_no_req", 64'(if_memctrl_en_out), 64'd0);
        wait_drain("t2_drain");

        // pc=0x4 hits; pc=0x8 misses and is redirected away while waiting.
        expect_fetch(32'h4, 32'h413, 1'b0);
        fetch_one();
        wait_drain("t3_hit4");
        exp_req.push_back(32'h8);
        instqueue_if_rdy_in = 1'b1;
        @(negedge clk_in);
        instqueue_if_rdy_in = 1'b0;
        redirect(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
        wait_drain("t3_drop");
        expect_fetch(32'h100, mem_word(32'h100), 1'b1);
        fetch_one();
        wait_drain("t3_fetch100");
        // The discarded reply still filled the line for 0x8.
        redirect(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
        expect_fetch(32'h8, 32'h813, 1'b0);
        fetch_one();
        chk("t3_hit8_no_req", 64'(if_memctrl_en_out), 64'd0);
        wait_drain("t3_hit8");

        // All three redirects together: rob wins, no push, no request.
        rob_if_rst_in = 1'b1;     rob_if_pc_in = 32'h200;
        bp_if_rst_in = 1'b1;      bp_if_pc_in = 32'h300;
        decoder_if_rst_in = 1'b1; decoder_if_pc_in = 32'h400;
        instqueue_if_rdy_in = 1'b1;
        @(negedge clk_in);
        rob_if_rst_in = 1'b0; bp_if_rst_in = 1'b0; decoder_if_rst_in = 1'b0;
        instqueue_if_rdy_in = 1'b0;
        chk("t5_redirect_quiet", {62'd0, if_instqueue_en_out, if_memctrl_en_out}, 64'd0);
        expect_fetch(32'h200, mem_word(32'h200), 1'b1);
        fetch_one();
        wait_drain("t5_rob_wins");
        // bp beats decoder.
        redirect(1'b0, 1'b1, 1'b1, 32'h0, 32'h300, 32'h400);
        expect_fetch(32'h300, mem_word(32'h300), 1'b1);
        fetch_one();
        wait_drain("t5_bp_wins");

        // 0x0 and 0x100 share index 0: every fetch misses.
        for (int i = 0; i < 3; i++) begin
            redirect(1'b1, 1'b0, 1'b0, t6[i], 32'h0, 32'h0);
            expect_fetch(t6[i], mem_word(t6[i]), 1'b1);
            fetch_one();
            wait_drain("t6_conflict");
        end

        // pc wraps from 0xFFFFFFFC to 0x0, which is resident.
        redirect(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        expect_fetch(32'hFFFF_FFFC, 32'hFFFF_FC13, 1'b1);
        fetch_one();
        wait_drain("wrap_top");
        expect_fetch(32'h0, 32'h13, 1'b0);
        fetch_one();
        chk("wrap_hit0", 64'(if_instqueue_en_out), 64'd1);
        wait_drain("wrap_drain");

        // Misaligned target: request is word aligned, pushed pc keeps low bits.
        redirect(1'b1, 1'b0, 1'b0, 32'h106, 32'h0, 32'h0);
        expect_fetch(32'h106, mem_word(32'h104), 1'b1);
        fetch_one();
        wait_drain("misaligned");

        // Global ready low: queue ready is ignored, nothing moves.
        rdy_in = 1'b0;
        instqueue_if_rdy_in = 1'b1;
        repeat (4) @(negedge clk_in);
        chk("rdy_low_frozen", {62'd0, if_instqueue_en_out, if_memctrl_en_out}, 64'd0);
        instqueue_if_rdy_in = 1'b0;
        rdy_in = 1'b1;
        repeat (3) @(negedge clk_in);

        chk("final_push_queue", 64'(exp_push.size()), 64'd0);
        chk("final_req_queue", 64'(exp_req.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
